// File: rtl/nx_egress_pkg.sv
// Shared types and constants for the host-bound egress arbiter.
package nx_egress_pkg;

  localparam int NX_MESSAGE_WIDTH    = 31;
  localparam int NX_EGRESS_BURST_W   = 4;
  localparam int NX_EGRESS_SRC_W_MAX = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } nx_egress_state_t;

  typedef struct packed {
    logic [NX_EGRESS_SRC_W_MAX-1:0] src;
    logic [NX_MESSAGE_WIDTH-1:0]    data;
  } nx_egress_msg_t;

  // A requested burst length of zero is treated as a single message.
  function automatic logic [NX_EGRESS_BURST_W-1:0] nx_egress_norm_burst(
    input logic [NX_EGRESS_BURST_W-1:0] len
  );
    return (len == '0) ? NX_EGRESS_BURST_W'(1) : len;
  endfunction

endpackage

// File: rtl/nx_egress_arbiter_rr_pick.sv
// Rotating first-one picker: finds the first set request strictly after
// ptr, wrapping modulo N. Purely combinational, reusable by other arbiters.
module nx_rr_pick #(
  parameter int N  = 4,
  parameter int SW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [SW-1:0] grant,
  output logic          found
);

  logic [SW:0]   sum;
  logic [SW-1:0] idx;

  // Scan ptr+1 .. ptr+N (mod N) and keep the first requester seen.
  always_comb begin
    grant = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int i = 1; i <= N; i++) begin
      sum = {1'b0, ptr} + (SW+1)'(i);
      if (sum >= (SW+1)'(N)) begin
        sum = sum - (SW+1)'(N);
      end
      idx = sum[SW-1:0];
      if (!found && req[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
  end

endmodule

// File: rtl/nx_egress_arbiter.sv
// Round-robin egress arbiter sharing the host message link between SOURCES
// requesters, with burst grants and a single registered output slot.
// Optional: define NX_EGRESS_PRIORITY_EN to give source 0 absolute priority
// at each arbitration decision (no preemption mid-burst).
module nx_egress_arbiter
  import nx_egress_pkg::*;
#(
  parameter int SOURCES = 4,
  parameter int WIDTH   = NX_MESSAGE_WIDTH,
  parameter int SRC_W   = $clog2(SOURCES)
) (
  input  logic                         clk_i,
  input  logic                         rstn_i,
  input  logic [SOURCES*WIDTH-1:0]     req_data_i,
  input  logic [SOURCES-1:0]           req_valid_i,
  output logic [SOURCES-1:0]           req_ready_o,
  input  logic [NX_EGRESS_BURST_W-1:0] burst_len_i,
  output logic [WIDTH-1:0]             out_data_o,
  output logic [SRC_W-1:0]             out_src_o,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic                         busy_o
);

  localparam int CW = NX_EGRESS_BURST_W + 1;

  nx_egress_state_t               state_q, state_d;
  logic [SRC_W-1:0]               grant_q, grant_d;
  logic [SRC_W-1:0]               rr_ptr_q, rr_ptr_d;
  logic [NX_EGRESS_BURST_W-1:0]   burst_cnt_q, burst_cnt_d;
  logic [NX_EGRESS_BURST_W-1:0]   burst_len_q, burst_len_d;
  logic [SRC_W-1:0]               pick_grant, arb_grant;
  logic                           pick_found;
  logic                           rr_update;
  logic                           slot_accepts, grant_valid, xfer, last_beat;
  logic [WIDTH-1:0]               grant_data;
  logic [WIDTH-1:0]               out_data_q;
  logic [SRC_W-1:0]               out_src_q;
  logic                           out_valid_q;

  nx_rr_pick #(
    .N  (SOURCES),
    .SW (SRC_W)
  ) u_pick (
    .req   (req_valid_i),
    .ptr   (rr_ptr_q),
    .grant (pick_grant),
    .found (pick_found)
  );

`ifdef NX_EGRESS_PRIORITY_EN
  // Source 0 jumps the queue and never moves the round-robin pointer.
  assign arb_grant = req_valid_i[0] ? '0 : pick_grant;
  assign rr_update = (grant_q != '0);
`else
  assign arb_grant = pick_grant;
  assign rr_update = 1'b1;
`endif

  assign slot_accepts = !out_valid_q || out_ready_i;
  assign xfer         = (state_q == GRANT) && slot_accepts && grant_valid;
  assign last_beat    = (CW'(burst_cnt_q) + CW'(1)) == CW'(burst_len_q);
  assign busy_o       = (state_q == GRANT) || out_valid_q;
  assign out_data_o   = out_data_q;
  assign out_src_o    = out_src_q;
  assign out_valid_o  = out_valid_q;

  // Route the granted source's valid and data onto shared internal wires.
  always_comb begin
    grant_valid = 1'b0;
    grant_data  = '0;
    for (int s = 0; s < SOURCES; s++) begin
      if (grant_q == SRC_W'(s)) begin
        grant_valid = req_valid_i[s];
        grant_data  = req_data_i[s*WIDTH +: WIDTH];
      end
    end
  end

  // Arbiter state registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= SRC_W'(SOURCES-1);
      burst_cnt_q <= '0;
      burst_len_q <= NX_EGRESS_BURST_W'(1);
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      burst_len_q <= burst_len_d;
    end
  end

  // Next-state logic: arbitrate in IDLE, count the burst in GRANT, and drive
  // the ready of the granted source whenever the output slot can take data.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    burst_len_d = burst_len_q;
    req_ready_o = '0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d     = arb_grant;
          burst_cnt_d = '0;
          burst_len_d = nx_egress_norm_burst(burst_len_i);
          state_d     = GRANT;
        end
      end
      GRANT: begin
        if (slot_accepts) begin
          for (int s = 0; s < SOURCES; s++) begin
            if (grant_q == SRC_W'(s)) begin
              req_ready_o[s] = 1'b1;
            end
          end
          if (!grant_valid) begin
            state_d = IDLE;
            if (rr_update) begin
              rr_ptr_d = grant_q;
            end
          end else begin
            burst_cnt_d = burst_cnt_q + NX_EGRESS_BURST_W'(1);
            if (last_beat) begin
              state_d = IDLE;
              if (rr_update) begin
                rr_ptr_d = grant_q;
              end
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Single-message output slot: loads on a granted transfer, empties when
  // downstream takes the message and nothing new arrives.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      out_data_q  <= '0;
      out_src_q   <= '0;
      out_valid_q <= 1'b0;
    end else if (slot_accepts) begin
      if (xfer) begin
        out_data_q  <= grant_data;
        out_src_q   <= grant_q;
        out_valid_q <= 1'b1;
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

endmodule
